// File: rtl/rcon_seq_gen_if.sv
// Handshake bundle between the key-schedule controller/consumer and the
// round-constant generator.
interface rcon_seq_gen_if #(
    parameter int unsigned OUT_WIDTH = 32,
    parameter int unsigned IDX_WIDTH = 4
);
    logic                 start;
    logic [1:0]           mode;
    logic                 rev;
    logic                 out_ready;
    logic                 out_valid;
    logic [OUT_WIDTH-1:0] rcon_out;
    logic [IDX_WIDTH-1:0] rcon_idx;
    logic                 last;
    logic                 busy;
    logic                 done;

    modport master (
        output start, mode, rev, out_ready,
        input  out_valid, rcon_out, rcon_idx, last, busy, done
    );

    modport slave (
        input  start, mode, rev, out_ready,
        output out_valid, rcon_out, rcon_idx, last, busy, done
    );
endinterface

// File: rtl/rcon_seq_gen.sv
// Sequential AES round-constant generator: walks the GF(2^8) xtime recurrence
// forward or backward and hands out one rcon word per valid/ready transfer.
module rcon_seq_gen #(
    parameter int unsigned OUT_WIDTH = 32,
    parameter int unsigned IDX_WIDTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    rcon_seq_gen_if.slave  bus
);
    localparam int unsigned PAD_WIDTH = OUT_WIDTH - 8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic                 valid_q, valid_d;
    logic                 busy_q, busy_d;
    logic                 last_q, last_d;
    logic                 done_q, done_d;
    logic [7:0]           val_q, val_d;
    logic [IDX_WIDTH-1:0] idx_q, idx_d;
    logic [1:0]           mode_q, mode_d;
    logic                 rev_q, rev_d;
    logic                 accept;
    logic                 xfer;

    function automatic logic [7:0] xtime_fwd(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Inverse of xtime: undo the reduction when the low bit shows it happened.
    function automatic logic [7:0] xtime_inv(input logic [7:0] x);
        return x[0] ? (((x ^ 8'h1b) >> 1) | 8'h80) : (x >> 1);
    endfunction

    function automatic logic [IDX_WIDTH-1:0] final_idx(input logic [1:0] m);
        case (m)
            2'b01:   return IDX_WIDTH'(7);
            2'b10:   return IDX_WIDTH'(6);
            default: return IDX_WIDTH'(9);
        endcase
    endfunction

    function automatic logic [7:0] final_rcon(input logic [1:0] m);
        case (m)
            2'b01:   return 8'h80;
            2'b10:   return 8'h40;
            default: return 8'h36;
        endcase
    endfunction

    assign accept = (state_q == ST_IDLE) && bus.start && (bus.mode != 2'b11);
    assign xfer   = valid_q && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_RUN;
            ST_RUN:  if (xfer && last_q) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs and the latched sequence setup.
    always_comb begin
        valid_d = valid_q;
        busy_d  = busy_q;
        last_d  = last_q;
        done_d  = 1'b0;
        val_d   = val_q;
        idx_d   = idx_q;
        mode_d  = mode_q;
        rev_d   = rev_q;
        case (state_q)
            ST_IDLE: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                last_d  = 1'b0;
                val_d   = 8'h00;
                idx_d   = '0;
                if (accept) begin
                    mode_d  = bus.mode;
                    rev_d   = bus.rev;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    val_d   = bus.rev ? final_rcon(bus.mode) : 8'h01;
                    idx_d   = bus.rev ? final_idx(bus.mode) : '0;
                end
            end
            ST_RUN: begin
                if (xfer && last_q) begin
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    last_d  = 1'b0;
                    done_d  = 1'b1;
                    val_d   = 8'h00;
                    idx_d   = '0;
                end else if (xfer) begin
                    val_d  = rev_q ? xtime_inv(val_q) : xtime_fwd(val_q);
                    idx_d  = rev_q ? idx_q - IDX_WIDTH'(1) : idx_q + IDX_WIDTH'(1);
                    last_d = rev_q ? (idx_d == '0) : (idx_d == final_idx(mode_q));
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            val_q   <= 8'h00;
            idx_q   <= '0;
            mode_q  <= 2'b00;
            rev_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            busy_q  <= busy_d;
            last_q  <= last_d;
            done_q  <= done_d;
            val_q   <= val_d;
            idx_q   <= idx_d;
            mode_q  <= mode_d;
            rev_q   <= rev_d;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.rcon_out  = OUT_WIDTH'(val_q) << PAD_WIDTH;
    assign bus.rcon_idx  = idx_q;
    assign bus.last      = last_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_rcon_seq_gen.sv
// Randomized self-checking bench for rcon_seq_gen; expected constants come
// from plain GF(2^8) multiplication by 2 starting at 1.
module tb_rcon_seq_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    rcon_seq_gen_if #(.OUT_WIDTH(32), .IDX_WIDTH(4)) bus32 ();
    rcon_seq_gen_if #(.OUT_WIDTH(8),  .IDX_WIDTH(4)) bus8 ();
    rcon_seq_gen_if #(.OUT_WIDTH(64), .IDX_WIDTH(4)) bus64 ();

    rcon_seq_gen #(.OUT_WIDTH(32), .IDX_WIDTH(4)) u_dut32 (.clk(clk), .rst(rst), .bus(bus32));
    rcon_seq_gen #(.OUT_WIDTH(8),  .IDX_WIDTH(4)) u_dut8  (.clk(clk), .rst(rst), .bus(bus8));
    rcon_seq_gen #(.OUT_WIDTH(64), .IDX_WIDTH(4)) u_dut64 (.clk(clk), .rst(rst), .bus(bus64));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // rcon[i] = 2^i in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] rcon_of(input int i);
        int v = 1;
        for (int j = 0; j < i; j++) begin
            v = v * 2;
            if (v > 255) v = v ^ 'h11b;
        end
        return 8'(v);
    endfunction

    function automatic int count_of(input logic [1:0] m);
        case (m)
            2'b01:   return 8;
            2'b10:   return 7;
            default: return 10;
        endcase
    endfunction

    // Runs one full sequence on the 32-bit instance; returns on the done cycle.
    task automatic run_seq(input logic [1:0] m, input logic r, input int stall_pct,
                           input int stall_at, input int stall_len, input bit noise);
        int n, k, cyc, stalled;
        logic [7:0] ev;
        logic [3:0] ei;
        logic       rdy;
        n = count_of(m); k = 0; cyc = 0; stalled = 0;
        bus32.start = 1'b1; bus32.mode = m; bus32.rev = r; bus32.out_ready = 1'b0;
        tick();
        bus32.start = 1'b0;
        while (k < n && cyc < 200) begin
            ev = r ? rcon_of(n - 1 - k) : rcon_of(k);
            ei = r ? 4'(n - 1 - k) : 4'(k);
            checks++;
            if ({bus32.out_valid, bus32.busy, bus32.done} !== 3'b110) begin
                failures++;
                $display("FAIL run_ctrl m=%0d r=%0d k=%0d valid/busy/done got %b want 110", m, r, k,
                         {bus32.out_valid, bus32.busy, bus32.done});
            end
            checks++;
            if (bus32.rcon_out !== {ev, 24'h0}) begin
                failures++;
                $display("FAIL run_rcon m=%0d r=%0d k=%0d got %h want %h", m, r, k, bus32.rcon_out, {ev, 24'h0});
            end
            checks++;
            if (bus32.rcon_idx !== ei) begin
                failures++;
                $display("FAIL run_idx m=%0d r=%0d k=%0d got %0d want %0d", m, r, k, bus32.rcon_idx, ei);
            end
            checks++;
            if (bus32.last !== 1'(k == n - 1)) begin
                failures++;
                $display("FAIL run_last m=%0d r=%0d k=%0d got %b want %b", m, r, k, bus32.last, (k == n - 1));
            end
            rdy = 1'($urandom_range(99) >= 32'(stall_pct));
            if (k == stall_at && stalled < stall_len) begin
                rdy = 1'b0;
                stalled++;
            end
            if (noise) begin
                bus32.start = 1'($urandom_range(1));
                bus32.mode  = 2'($urandom_range(3));
                bus32.rev   = 1'($urandom_range(1));
            end
            bus32.out_ready = rdy;
            tick();
            if (rdy) k++;
            cyc++;
        end
        bus32.start = 1'b0;
        bus32.out_ready = 1'($urandom_range(1));
        checks++;
        if (k != n) begin
            failures++;
            $display("FAIL run_timeout m=%0d r=%0d words got %0d want %0d", m, r, k, n);
        end
        checks++;
        if ({bus32.out_valid, bus32.busy, bus32.done} !== 3'b001) begin
            failures++;
            $display("FAIL run_done m=%0d r=%0d valid/busy/done got %b want 001", m, r,
                     {bus32.out_valid, bus32.busy, bus32.done});
        end
    endtask

    task automatic test_reset();
        tick(); tick();
        checks++;
        if ({bus32.out_valid, bus32.last, bus32.busy, bus32.done, bus32.rcon_idx, bus32.rcon_out} !== '0) begin
            failures++;
            $display("FAIL reset32 outputs got %b/%h want all zero", bus32.out_valid, bus32.rcon_out);
        end
        checks++;
        if ({bus8.out_valid, bus8.busy, bus8.done, bus8.rcon_out, bus64.out_valid, bus64.done, bus64.rcon_out} !== '0) begin
            failures++;
            $display("FAIL reset_widths outputs got %h/%h want 0", bus8.rcon_out, bus64.rcon_out);
        end
        rst = 1'b0;
    endtask

    task automatic test_idle_after(input string tag);
        tick();
        checks++;
        if ({bus32.out_valid, bus32.busy, bus32.done} !== 3'b000) begin
            failures++;
            $display("FAIL %s_idle valid/busy/done got %b want 000", tag, {bus32.out_valid, bus32.busy, bus32.done});
        end
    endtask

    task automatic test_fwd128();
        run_seq(2'b00, 1'b0, 0, -1, 0, 1'b0);
        test_idle_after("fwd128");
    endtask

    task automatic test_rev256();
        run_seq(2'b10, 1'b1, 0, -1, 0, 1'b0);
        test_idle_after("rev256");
    endtask

    task automatic test_back_to_back();
        run_seq(2'b01, 1'b1, 0, -1, 0, 1'b0);
        run_seq(2'b00, 1'b0, 0, -1, 0, 1'b0);
        test_idle_after("b2b");
    endtask

    task automatic test_backpressure();
        run_seq(2'b01, 1'b0, 0, 2, 3, 1'b0);
        test_idle_after("bp");
    endtask

    task automatic test_ignored_start();
        bus32.start = 1'b1; bus32.mode = 2'b11; bus32.rev = 1'($urandom_range(1));
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({bus32.out_valid, bus32.busy} !== 2'b00) begin
                failures++;
                $display("FAIL mode11 cyc=%0d valid/busy got %b want 00", i, {bus32.out_valid, bus32.busy});
            end
        end
        bus32.start = 1'b0;
        run_seq(2'b10, 1'b0, 0, -1, 0, 1'b1);
        test_idle_after("noise256");
    endtask

    task automatic test_reset_mid();
        bus32.start = 1'b1; bus32.mode = 2'b00; bus32.rev = 1'b0; bus32.out_ready = 1'b0;
        tick();
        bus32.start = 1'b0; bus32.out_ready = 1'b1;
        repeat (4) tick();
        checks++;
        if (bus32.rcon_out !== 32'h1000_0000) begin
            failures++;
            $display("FAIL mid_pre rcon got %h want 10000000", bus32.rcon_out);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({bus32.out_valid, bus32.last, bus32.busy, bus32.done, bus32.rcon_idx, bus32.rcon_out} !== '0) begin
            failures++;
            $display("FAIL mid_reset valid=%b rcon=%h done=%b want zeros", bus32.out_valid, bus32.rcon_out, bus32.done);
        end
        test_idle_after("mid_reset");
        run_seq(2'b00, 1'b0, 20, -1, 0, 1'b0);
        test_idle_after("after_reset");
    endtask

    task automatic test_widths();
        bus8.start = 1'b1;  bus8.mode = 2'b00;  bus8.rev = 1'b0;  bus8.out_ready = 1'b1;
        bus64.start = 1'b1; bus64.mode = 2'b00; bus64.rev = 1'b0; bus64.out_ready = 1'b1;
        tick();
        bus8.start = 1'b0; bus64.start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (bus8.rcon_out !== rcon_of(k) || bus8.out_valid !== 1'b1) begin
                failures++;
                $display("FAIL w8 k=%0d got %h want %h", k, bus8.rcon_out, rcon_of(k));
            end
            checks++;
            if (bus64.rcon_out !== {rcon_of(k), 56'h0}) begin
                failures++;
                $display("FAIL w64 k=%0d got %h want %h", k, bus64.rcon_out, {rcon_of(k), 56'h0});
            end
            tick();
        end
        checks++;
        if ({bus8.done, bus64.done, bus8.out_valid, bus64.out_valid} !== 4'b1100) begin
            failures++;
            $display("FAIL w_done done8/done64/valid8/valid64 got %b want 1100",
                     {bus8.done, bus64.done, bus8.out_valid, bus64.out_valid});
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 10; it++) begin
            run_seq(2'($urandom_range(2)), 1'($urandom_range(1)), 35, -1, 0, 1'b1);
            if ($urandom_range(1) == 1) test_idle_after("rand");
        end
        test_idle_after("rand_end");
    endtask

    initial begin
        bus32.start = 1'b0; bus32.mode = 2'b00; bus32.rev = 1'b0; bus32.out_ready = 1'b0;
        bus8.start  = 1'b0; bus8.mode  = 2'b00; bus8.rev  = 1'b0; bus8.out_ready  = 1'b0;
        bus64.start = 1'b0; bus64.mode = 2'b00; bus64.rev = 1'b0; bus64.out_ready = 1'b0;
        test_reset();
        test_fwd128();
        test_rev256();
        test_back_to_back();
        test_backpressure();
        test_ignored_start();
        test_reset_mid();
        test_widths();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
